tmr_counter_ctrl: RTL and testbench

Parametrised triple-modular-redundant up/down counter. Adds synchronous load, wrap or saturate mode, and a terminal-count flag. Tracks faults per replica (OK/SUSPECT/FAILED), excludes failed replicas from the vote, and keeps a saturating corrected-error counter. It is the drop-in successor to the fixed 16-bit up-only TMR counter in the radiation-hardened flow.

---
 rtl/tmr_counter_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tmr_counter_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_counter_ctrl.sv
// Triple-modular-redundant up/down counter with per-replica fault tracking and voting.
// Optional macro TMR_RECOVER_EN: FAILED replicas that track the vote long enough rejoin it.
module tmr_counter_ctrl #(
  parameter int WIDTH        = 16,
  parameter int FAULT_THRESH = 4,
  parameter int ERRCNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                up_down,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                sat_mode,
  input  logic                clr_status,
  output logic [WIDTH-1:0]    q_out,
  output logic                tc,
  output logic [2:0]          fault_vec,
  output logic [2:0]          failed_vec,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                uncorrectable
);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAILED} state_e;

  localparam logic [3:0]       THRESH  = 4'(FAULT_THRESH);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0]    r0_q, r1_q, r2_q;
  logic [WIDTH-1:0]    cnt_d, vote;
  logic [WIDTH-1:0]    rep [3];
  state_e              state_q [3];
  state_e              state_d [3];
  logic [3:0]          mc_q [3];
  logic [3:0]          mc_d [3];
  logic [ERRCNT_W-1:0] err_q, err_d;
  logic [2:0]          failed, mismatch;

  assign rep[0] = r0_q;
  assign rep[1] = r1_q;
  assign rep[2] = r2_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      failed[i]   = (state_q[i] == ST_FAILED);
      mismatch[i] = (rep[i] != vote);
    end
  end

  // Failed replicas are dropped; with one left out, a disagreement falls back to the lower index.
  always_comb begin
    vote          = r0_q;
    uncorrectable = 1'b0;
    case (failed)
      3'b000: vote = (r0_q & r1_q) | (r0_q & r2_q) | (r1_q & r2_q);
      3'b001: begin vote = r1_q; uncorrectable = (r1_q != r2_q); end
      3'b010: begin vote = r0_q; uncorrectable = (r0_q != r2_q); end
      3'b100: begin vote = r0_q; uncorrectable = (r0_q != r1_q); end
      3'b011: begin vote = r2_q; uncorrectable = 1'b1; end
      3'b101: begin vote = r1_q; uncorrectable = 1'b1; end
      3'b110: begin vote = r0_q; uncorrectable = 1'b1; end
      default: begin vote = r0_q; uncorrectable = 1'b1; end
    endcase
  end

  assign q_out      = vote;
  assign fault_vec  = mismatch & ~failed;
  assign failed_vec = failed;
  assign err_cnt    = err_q;

  always_comb begin
    cnt_d = vote;
    tc    = 1'b0;
    if (enable && load) begin
      cnt_d = load_val;
    end else if (enable) begin
      if (up_down) begin
        tc    = (vote == MAX_VAL);
        cnt_d = (sat_mode && vote == MAX_VAL) ? vote : vote + 1'b1;
      end else begin
        tc    = (vote == '0);
        cnt_d = (sat_mode && vote == '0) ? vote : vote - 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr_status)
      err_d = '0;
    else if (|fault_vec && err_q != '1)
      err_d = err_q + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      mc_d[i]    = mc_q[i];
      if (clr_status) begin
        state_d[i] = ST_OK;
        mc_d[i]    = '0;
      end else begin
        case (state_q[i])
          ST_OK: begin
            if (fault_vec[i]) begin
              if (THRESH == 4'd1) begin
                state_d[i] = ST_FAILED;
                mc_d[i]    = '0;
              end else begin
                state_d[i] = ST_SUSPECT;
                mc_d[i]    = 4'd1;
              end
            end
          end
          ST_SUSPECT: begin
            if (fault_vec[i]) begin
              if (mc_q[i] + 4'd1 == THRESH) begin
                state_d[i] = ST_FAILED;
                mc_d[i]    = '0;
              end else begin
                mc_d[i] = mc_q[i] + 4'd1;
              end
            end else begin
              state_d[i] = ST_OK;
              mc_d[i]    = '0;
            end
          end
          ST_FAILED: begin
`ifdef TMR_RECOVER_EN
            // In FAILED the mismatch counter is reused to count consecutive matches.
            if (mismatch[i]) begin
              mc_d[i] = '0;
            end else if (mc_q[i] + 4'd1 == THRESH) begin
              state_d[i] = ST_OK;
              mc_d[i]    = '0;
            end else begin
              mc_d[i] = mc_q[i] + 4'd1;
            end
`endif
          end
          default: begin
            state_d[i] = ST_OK;
            mc_d[i]    = '0;
          end
        endcase
      end
    end
  end

  // Every replica, healthy or not, is rewritten from the vote so upsets scrub in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      err_q <= '0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_OK;
        mc_q[i]    <= '0;
      end
    end else begin
      r0_q  <= cnt_d;
      r1_q  <= cnt_d;
      r2_q  <= cnt_d;
      err_q <= err_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        mc_q[i]    <= mc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tmr_counter_ctrl.sv
// Self-checking bench for tmr_counter_ctrl: directed scenarios followed by random stimulus,
// with replica upsets injected by forcing the replica registers.
module tb_tmr_counter_ctrl;

   localparam int W     = 16;
   localparam int THR   = 4;
   localparam int EW    = 8;
   localparam int MAXV  = 65535;
   localparam int EMAX  = 255;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          up_down;
   logic          load;
   logic [W-1:0]  load_val;
   logic          sat_mode;
   logic          clr_status;
   logic [W-1:0]  q_out;
   logic          tc;
   logic [2:0]    fault_vec;
   logic [2:0]    failed_vec;
   logic [EW-1:0] err_cnt;
   logic          uncorrectable;

   int nChecks;
   int nErrors;

   // Reference model: replica contents as written, per-replica state (0 OK, 1 SUSPECT, 2 FAILED)
   int            mSt [3];
   int            mMc [3];
   logic [W-1:0]  mRep [3];
   int            mErr;

   // Injection plan: one-cycle transient value or a stuck bit held for a number of cycles
   bit            trEn [3];
   logic [W-1:0]  trVal [3];
   int            stuckLeft [3];
   int            stuckBit [3];
   bit            stuckVal [3];
   bit            forced [3];
   logic [W-1:0]  eff [3];
   logic [W-1:0]  inj0, inj1, inj2;

   tmr_counter_ctrl #(.WIDTH(W), .FAULT_THRESH(THR), .ERRCNT_W(EW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
      .load_val(load_val), .sat_mode(sat_mode), .clr_status(clr_status),
      .q_out(q_out), .tc(tc), .fault_vec(fault_vec), .failed_vec(failed_vec),
      .err_cnt(err_cnt), .uncorrectable(uncorrectable)
   );

   // Free-running 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Replica overrides need static hierarchical targets, hence the case on the index
   task automatic setForce(input int i, input logic [W-1:0] v);
      case (i)
         0: begin inj0 = v; force dut.r0_q = inj0; end
         1: begin inj1 = v; force dut.r1_q = inj1; end
         default: begin inj2 = v; force dut.r2_q = inj2; end
      endcase
   endtask

   task automatic releaseRep(input int i);
      case (i)
         0: release dut.r0_q;
         1: release dut.r1_q;
         default: release dut.r2_q;
      endcase
   endtask

   // Asynchronous reset away from any clock edge, with outputs checked while it is held
   task automatic resetDut();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (forced[i]) releaseRep(i);
         forced[i]    = 1'b0;
         trEn[i]      = 1'b0;
         stuckLeft[i] = 0;
      end
      enable = 1'b0; load = 1'b0; clr_status = 1'b0;
      up_down = 1'b0; sat_mode = 1'b0; load_val = '0;
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_q", 32'(q_out), 32'd0);
      checkOutput("rst_tc", 32'(tc), 32'd0);
      checkOutput("rst_fault", 32'(fault_vec), 32'd0);
      checkOutput("rst_failed", 32'(failed_vec), 32'd0);
      checkOutput("rst_err", 32'(err_cnt), 32'd0);
      checkOutput("rst_unc", 32'(uncorrectable), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mSt[i] = 0; mMc[i] = 0; mRep[i] = '0;
      end
      mErr = 0;
   endtask

   // One clock cycle: drive inputs and injections, compare against the model, advance the model
   task automatic applyStimulus(input bit en, input bit ud, input bit ld,
                                input logic [W-1:0] lv, input bit sat, input bit clr);
      int            healthy [$];
      logic [W-1:0]  vote;
      bit            unc;
      logic [2:0]    fv, fl;
      bit            expTc;
      int            v, nxt, ones;
      @(negedge clk);
      enable = en; up_down = ud; load = ld; load_val = lv; sat_mode = sat; clr_status = clr;
      for (int i = 0; i < 3; i++) begin
         eff[i] = mRep[i];
         if (trEn[i]) eff[i] = trVal[i];
         else if (stuckLeft[i] > 0) eff[i][stuckBit[i]] = stuckVal[i];
         if (trEn[i] || stuckLeft[i] > 0) begin
            setForce(i, eff[i]);
            forced[i] = 1'b1;
         end else if (forced[i]) begin
            setForce(i, mRep[i]);
            releaseRep(i);
            forced[i] = 1'b0;
         end
      end
      #1;
      for (int i = 0; i < 3; i++) if (mSt[i] != 2) healthy.push_back(i);
      vote = eff[0];
      unc  = 1'b1;
      if (healthy.size() == 3) begin
         unc = 1'b0;
         for (int b = 0; b < W; b++) begin
            ones = int'(eff[0][b]) + int'(eff[1][b]) + int'(eff[2][b]);
            vote[b] = (ones >= 2);
         end
      end else if (healthy.size() == 2) begin
         vote = eff[healthy[0]];
         unc  = (eff[healthy[0]] != eff[healthy[1]]);
      end else if (healthy.size() == 1) begin
         vote = eff[healthy[0]];
      end
      for (int i = 0; i < 3; i++) begin
         fl[i] = (mSt[i] == 2);
         fv[i] = !fl[i] && (eff[i] != vote);
      end
      expTc = en && !ld && (ud ? (vote == 16'hFFFF) : (vote == 16'h0000));
      checkOutput("q_out", 32'(q_out), 32'(vote));
      checkOutput("tc", 32'(tc), 32'(expTc));
      checkOutput("fault_vec", 32'(fault_vec), 32'(fv));
      checkOutput("failed_vec", 32'(failed_vec), 32'(fl));
      checkOutput("err_cnt", 32'(err_cnt), 32'(mErr));
      checkOutput("uncorrectable", 32'(uncorrectable), 32'(unc));

      v = int'(vote);
      if (en && ld) nxt = int'(lv);
      else if (en && ud) nxt = (sat && v == MAXV) ? v : (v + 1) % (MAXV + 1);
      else if (en) nxt = (sat && v == 0) ? 0 : (v + MAXV) % (MAXV + 1);
      else nxt = v;

      if (clr) begin
         mErr = 0;
         for (int i = 0; i < 3; i++) begin mSt[i] = 0; mMc[i] = 0; end
      end else begin
         if (fv != 3'b000 && mErr < EMAX) mErr++;
         for (int i = 0; i < 3; i++) begin
            if (mSt[i] == 0) begin
               if (fv[i]) begin
                  if (THR == 1) begin mSt[i] = 2; mMc[i] = 0; end
                  else begin mSt[i] = 1; mMc[i] = 1; end
               end
            end else if (mSt[i] == 1) begin
               if (fv[i]) begin
                  mMc[i]++;
                  if (mMc[i] == THR) begin mSt[i] = 2; mMc[i] = 0; end
               end else begin
                  mSt[i] = 0; mMc[i] = 0;
               end
            end else begin
`ifdef TMR_RECOVER_EN
               if (eff[i] == vote) begin
                  mMc[i]++;
                  if (mMc[i] == THR) begin mSt[i] = 0; mMc[i] = 0; end
               end else begin
                  mMc[i] = 0;
               end
`endif
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         mRep[i] = W'(nxt);
         trEn[i] = 1'b0;
         if (stuckLeft[i] > 0) stuckLeft[i]--;
      end
      @(posedge clk);
   endtask

   // Directed scenarios first, then a long randomized run
   initial begin
      int        r, pick;
      logic [W-1:0] lv;
      nChecks = 0;
      nErrors = 0;
      rst = 1'b1;
      enable = 1'b0; up_down = 1'b0; load = 1'b0; load_val = '0;
      sat_mode = 1'b0; clr_status = 1'b0;
      inj0 = '0; inj1 = '0; inj2 = '0;
      for (int i = 0; i < 3; i++) begin
         forced[i] = 1'b0; trEn[i] = 1'b0; trVal[i] = '0;
         stuckLeft[i] = 0; stuckBit[i] = 0; stuckVal[i] = 1'b0;
      end
      resetDut();

      // Wrap-mode counting through the top of the range
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1, 1, 0, '0, 0, 0);
         #1 checkOutput("plan_count_up", 32'(q_out), 32'(k));
      end
      applyStimulus(1, 1, 1, 16'hFFFE, 0, 0);
      #1 checkOutput("plan_load", 32'(q_out), 32'h0000FFFE);
      applyStimulus(1, 1, 0, '0, 0, 0);
      #1 checkOutput("plan_max", 32'(q_out), 32'h0000FFFF);
      checkOutput("plan_tc_up", 32'(tc), 32'd1);
      applyStimulus(1, 1, 0, '0, 0, 0);
      #1 checkOutput("plan_wrap", 32'(q_out), 32'd0);

      // Saturating down-count holds at zero
      applyStimulus(1, 0, 1, 16'h0001, 1, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 0, 0, '0, 1, 0);
         #1 checkOutput("plan_sat_down", 32'(q_out), 32'd0);
         checkOutput("plan_tc_down", 32'(tc), 32'd1);
      end

      // Single-cycle upset on r1 is outvoted and scrubbed
      applyStimulus(1, 1, 1, 16'h0010, 0, 0);
      trEn[1] = 1'b1; trVal[1] = 16'h00FF;
      applyStimulus(0, 1, 0, '0, 0, 0);
      #1 checkOutput("plan_seu_q", 32'(q_out), 32'h00000010);
      checkOutput("plan_seu_err", 32'(err_cnt), 32'd1);
      applyStimulus(0, 1, 0, '0, 0, 0);

      // Stuck bit on r2 drives it to FAILED after THR mismatches
      applyStimulus(1, 1, 1, 16'h0002, 0, 0);
      stuckLeft[2] = THR; stuckBit[2] = 0; stuckVal[2] = 1'b1;
      repeat (THR) applyStimulus(0, 1, 0, '0, 0, 0);
      #1 checkOutput("plan_failed", 32'(failed_vec), 32'b100);
      checkOutput("plan_stuck_err", 32'(err_cnt), 32'd5);

      // Healthy pair disagrees with r2 out of the vote
      trEn[0] = 1'b1; trVal[0] = 16'h1234;
      applyStimulus(0, 1, 0, '0, 0, 0);
      #1 checkOutput("plan_unc_q", 32'(q_out), 32'h00001234);

      // clr_status wins over a same-cycle mismatch
      trEn[1] = 1'b1; trVal[1] = 16'h0F0F;
      applyStimulus(0, 1, 0, '0, 0, 1);
      #1 checkOutput("plan_clr_failed", 32'(failed_vec), 32'd0);
      checkOutput("plan_clr_err", 32'(err_cnt), 32'd0);

      // Fail r2 again, then let it track the vote
      applyStimulus(1, 1, 1, 16'h0002, 0, 0);
      stuckLeft[2] = THR; stuckBit[2] = 0; stuckVal[2] = 1'b1;
      repeat (THR) applyStimulus(0, 1, 0, '0, 0, 0);
      repeat (THR) applyStimulus(0, 1, 0, '0, 0, 0);
`ifdef TMR_RECOVER_EN
      #1 checkOutput("plan_recover", 32'(failed_vec), 32'd0);
`else
      #1 checkOutput("plan_sticky", 32'(failed_vec), 32'b100);
`endif

      // Randomized run with occasional upsets, clears, boundary loads and resets
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 999) < 3) begin
            resetDut();
         end else begin
            if ($urandom_range(0, 99) < 5) begin
               r = $urandom_range(0, 2);
               trEn[r] = 1'b1;
               trVal[r] = W'($urandom);
            end
            if ($urandom_range(0, 99) < 3) begin
               r = $urandom_range(0, 2);
               if (stuckLeft[r] == 0) begin
                  stuckLeft[r] = $urandom_range(1, 7);
                  stuckBit[r]  = $urandom_range(0, W - 1);
                  stuckVal[r]  = 1'($urandom);
               end
            end
            pick = $urandom_range(0, 3);
            case (pick)
               0: lv = 16'h0000;
               1: lv = 16'hFFFF;
               2: lv = ($urandom_range(0, 1) == 1) ? 16'h0001 : 16'hFFFE;
               default: lv = W'($urandom);
            endcase
            applyStimulus($urandom_range(0, 9) < 8, 1'($urandom),
                          $urandom_range(0, 9) == 0, lv, 1'($urandom),
                          $urandom_range(0, 49) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
